avalon_vip_csr: RTL
===================

// Module: avalon_vip_csr
// PURPOSE
// Parametrised Avalon-MM control/status block for the VIP pixel pipeline (clk domain).
// Holds stage enables and downscale factor in staged registers and applies them to the
// pipeline only at a frame boundary, so configuration never changes mid-frame.
// Synchronises input/output vsync from pclk and raises maskable W1C frame interrupts.
// PARAMETERS
// NUM_EN      4     number of pipeline stage-enable bits (1..32)
// EN_RESET    4'hE  reset value of the stage enables (NUM_EN bits)
// SCALE_BITS  4     width of the downscale factor (1..32)
// SCALE_RESET 1     reset value of the downscale factor
// ADDR_W      6     Avalon slave word-address width
// PORTS
// clk            in   1          CSR clock
// reset          in   1          asynchronous, active-high reset
// as_address     in   ADDR_W     word address
// as_read        in   1          read strobe; fixed read latency 1
// as_readdata    out  32         registered read data
// as_write       in   1          write strobe
// as_writedata   in   32         write data
// irq            out  1          |(INT_STATUS & ~INT_MASK)
// vsync_in       in   1          pipeline input vsync, pclk domain (async here)
// vsync_out      in   1          pipeline output vsync, pclk domain (async here)
// module_reset   out  1          pipeline soft reset, active-high
// stage_en       out  NUM_EN     active stage enables
// dscale_scale   out  SCALE_BITS active downscale factor
// cfg_applied    out  1          1-clk pulse when staged config is copied to active
// BEHAVIOUR
// - Reset: module_reset=1, stage_en/staged=EN_RESET, dscale_scale/staged=SCALE_RESET,
//   INT_STATUS=0, INT_MASK=3'b111, CTRL=0, as_readdata=0, cfg_applied=0, irq=0.
// - Map (word addr): 0 RESET b0 module_reset | 1 TOP_EN staged enables | 2 DSCALE staged
//   scale | 3 INT_STATUS b0 frame_done b1 frame_start b2 cfg_applied, W1C per bit |
//   4 INT_MASK [2:0], 1=masked | 5 CTRL b0 commit_pending (write 1 sets, write 0 no
//   effect) b1 auto_commit (R/W) | 6 FRAME_CNT (see CONFIGURATION) | others read 0.
// - TOP_EN/DSCALE read back the staged value, not the active one; unused bits read 0.
// - Reads: as_readdata updated on the clk edge sampling as_read, holds otherwise; same-
//   cycle read+write both execute, readdata returns pre-write value.
// - Each vsync passes a 2-FF synchroniser then a registered edge detector; rising edge
//   flags (fs_edge, fd_edge) assert 3 clk after first sampling high; 1-clk wide each.
// - fs_edge sets INT_STATUS[1]; fd_edge sets INT_STATUS[0]. Hardware set wins over a
//   same-cycle W1C of that bit.
// - Apply: on fs_edge when (commit_pending | auto_commit): active <= staged, clear
//   commit_pending, cfg_applied pulse, set INT_STATUS[2]. A CTRL commit write in the
//   same cycle as an applying fs_edge leaves commit_pending=1 for the next frame.
// - While module_reset=1 active tracks staged every cycle (pipeline idle); no pulse/irq.
// - Writing RESET 1->0 does not change active values; next change needs commit/auto.
// - Mid-frame async reset returns everything to reset values immediately.
// CONFIGURATION
// - AVALON_VIP_FRAME_CNT_EN defined: addr 6 = 32-bit count of fd_edge events, wraps
//   0xFFFFFFFF->0, any write clears it; a same-cycle fd_edge loses to the clear.
// - Undefined: no counter logic; addr 6 reads 0, writes ignored.
// TESTING
// - Reset release: read addr 0/1/2/4 -> 1, EN_RESET, SCALE_RESET, 7; irq=0.
// - RESET=0, write TOP_EN=5, no commit, pulse vsync_in -> stage_en stays EN_RESET;
//   write CTRL=1, pulse vsync_in -> stage_en=5, cfg_applied 1 clk, INT_STATUS[2]=1.
// - INT_MASK=6, pulse vsync_out -> INT_STATUS=1, irq=1; write INT_STATUS=2 -> still 1;
//   write INT_STATUS=1 -> 0, irq=0; W1C same cycle as fd_edge -> bit stays 1.
// - auto_commit=1, write DSCALE=3 mid-frame -> dscale_scale unchanged until fs_edge,
//   then 3; CTRL commit write on fs_edge cycle -> CTRL reads 1 afterwards.
// - With AVALON_VIP_FRAME_CNT_EN: 5 vsync_out pulses -> addr 6 reads 5; write -> 0.
// - Assert reset mid-frame with pending commit -> all reset values, CTRL reads 0.

Source files
------------

// File: rtl/avalon_vip_csr_if.sv
// Avalon-MM slave bus bundle for the VIP CSR block (word addressed, read latency 1).
interface avalon_vip_csr_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] as_address;
  logic              as_read;
  logic [31:0]       as_readdata;
  logic              as_write;
  logic [31:0]       as_writedata;

  modport master (output as_address, as_read, as_write, as_writedata, input as_readdata);
  modport slave  (input as_address, as_read, as_write, as_writedata, output as_readdata);
endinterface

// File: rtl/avalon_vip_csr.sv
// VIP pipeline control/status block: staged config applied at frame start, vsync
// synchronisers and W1C frame interrupts. Optional frame counter: AVALON_VIP_FRAME_CNT_EN.

// 2-FF synchroniser followed by a registered rising-edge detector.
module avalon_vip_csr_vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      rise      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], d};
      rise      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end
endmodule

module avalon_vip_csr #(
  parameter int                    NUM_EN      = 4,
  parameter logic [NUM_EN-1:0]     EN_RESET    = 4'hE,
  parameter int                    SCALE_BITS  = 4,
  parameter logic [SCALE_BITS-1:0] SCALE_RESET = SCALE_BITS'(1),
  parameter int                    ADDR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_vip_csr_if.slave       csr,
  output logic                  irq,
  input  logic                  vsync_in,
  input  logic                  vsync_out,
  output logic                  module_reset,
  output logic [NUM_EN-1:0]     stage_en,
  output logic [SCALE_BITS-1:0] dscale_scale,
  output logic                  cfg_applied
);
  localparam logic [ADDR_W-1:0] A_RESET      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TOP_EN     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DSCALE     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_INT_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_INT_MASK   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL       = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_FRAME_CNT  = ADDR_W'(6);

  logic [NUM_EN-1:0]     en_staged;
  logic [SCALE_BITS-1:0] sc_staged;
  logic [2:0]            int_status, int_mask, int_set, int_clr;
  logic                  commit_pending, auto_commit;
  logic [31:0]           readdata, rd_mux, frame_cnt_rd;
  logic                  fs_edge, fd_edge, apply;
  logic [1:0]            vs_raw, vs_rise;
  logic                  wr_reset, wr_top_en, wr_dscale, wr_int_status, wr_int_mask, wr_ctrl;
  logic                  unused_wdata;

  // bit 0: input vsync (frame start), bit 1: output vsync (frame done)
  assign vs_raw = {vsync_out, vsync_in};
  for (genvar g = 0; g < 2; g++) begin : g_vs
    avalon_vip_csr_vsync_edge u_edge (
      .clk  (clk),
      .reset(reset),
      .d    (vs_raw[g]),
      .rise (vs_rise[g])
    );
  end
  assign fs_edge = vs_rise[0];
  assign fd_edge = vs_rise[1];

  assign wr_reset      = csr.as_write && (csr.as_address == A_RESET);
  assign wr_top_en     = csr.as_write && (csr.as_address == A_TOP_EN);
  assign wr_dscale     = csr.as_write && (csr.as_address == A_DSCALE);
  assign wr_int_status = csr.as_write && (csr.as_address == A_INT_STATUS);
  assign wr_int_mask   = csr.as_write && (csr.as_address == A_INT_MASK);
  assign wr_ctrl       = csr.as_write && (csr.as_address == A_CTRL);
  assign unused_wdata  = ^csr.as_writedata;

  // The pipeline is idle while held in soft reset, so frame events are ignored then.
  assign apply   = fs_edge & (commit_pending | auto_commit) & ~module_reset;
  assign int_set = module_reset ? 3'b000 : {apply, fs_edge, fd_edge};
  assign int_clr = wr_int_status ? csr.as_writedata[2:0] : 3'b000;
  assign irq     = |(int_status & ~int_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      module_reset   <= 1'b1;
      en_staged      <= EN_RESET;
      stage_en       <= EN_RESET;
      sc_staged      <= SCALE_RESET;
      dscale_scale   <= SCALE_RESET;
      int_status     <= 3'b000;
      int_mask       <= 3'b111;
      commit_pending <= 1'b0;
      auto_commit    <= 1'b0;
      cfg_applied    <= 1'b0;
    end else begin
      if (wr_reset)    module_reset <= csr.as_writedata[0];
      if (wr_top_en)   en_staged    <= csr.as_writedata[NUM_EN-1:0];
      if (wr_dscale)   sc_staged    <= csr.as_writedata[SCALE_BITS-1:0];
      if (wr_int_mask) int_mask     <= csr.as_writedata[2:0];
      if (wr_ctrl)     auto_commit  <= csr.as_writedata[1];
      // hardware set beats a same-cycle W1C
      int_status <= (int_status & ~int_clr) | int_set;
      // a commit request landing on an applying edge is kept for the next frame
      if (wr_ctrl && csr.as_writedata[0]) commit_pending <= 1'b1;
      else if (apply)                     commit_pending <= 1'b0;
      cfg_applied <= apply;
      if (module_reset || apply) begin
        stage_en     <= en_staged;
        dscale_scale <= sc_staged;
      end
    end
  end

`ifdef AVALON_VIP_FRAME_CNT_EN
  logic [31:0] frame_cnt;
  logic        wr_frame_cnt;
  assign wr_frame_cnt = csr.as_write && (csr.as_address == A_FRAME_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             frame_cnt <= '0;
    else if (wr_frame_cnt) frame_cnt <= '0;
    else if (fd_edge)      frame_cnt <= frame_cnt + 32'd1;
  end
  assign frame_cnt_rd = frame_cnt;
`else
  assign frame_cnt_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (csr.as_address)
      A_RESET:      rd_mux[0]              = module_reset;
      A_TOP_EN:     rd_mux[NUM_EN-1:0]     = en_staged;
      A_DSCALE:     rd_mux[SCALE_BITS-1:0] = sc_staged;
      A_INT_STATUS: rd_mux[2:0]            = int_status;
      A_INT_MASK:   rd_mux[2:0]            = int_mask;
      A_CTRL:       rd_mux[1:0]            = {auto_commit, commit_pending};
      A_FRAME_CNT:  rd_mux                 = frame_cnt_rd;
      default:      rd_mux                 = '0;
    endcase
  end

  // pre-write value is returned on a same-cycle read+write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            readdata <= '0;
    else if (csr.as_read) readdata <= rd_mux;
  end
  assign csr.as_readdata = readdata;
endmodule
